// File: rtl/fetch_queue.sv
// fetch_queue: compacting instruction queue between fetch and decode/issue.
// It takes fetch packets with a per-slot valid mask, packs the valid slots into
// a circular buffer, and presents up to ISSUE_WIDTH entries per cycle in
// program order. A fault packet leaves one marker entry and then blocks fetch
// until the next flush.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a packet
// pushed into an empty queue drives the output lanes in the same cycle.
module fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int DEPTH_W     = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_accept_o,
  input  logic [31:0]                in_pc_i,
  input  logic [32*FETCH_WIDTH-1:0]  in_instr_i,
  input  logic [FETCH_WIDTH-1:0]     in_mask_i,
  input  logic [FETCH_WIDTH-1:0]     in_pred_taken_i,
  input  logic                       in_fault_fetch_i,
  input  logic                       in_fault_page_i,
  output logic [ISSUE_WIDTH-1:0]     out_valid_o,
  output logic [32*ISSUE_WIDTH-1:0]  out_instr_o,
  output logic [32*ISSUE_WIDTH-1:0]  out_pc_o,
  output logic [ISSUE_WIDTH-1:0]     out_fault_fetch_o,
  output logic [ISSUE_WIDTH-1:0]     out_fault_page_o,
  output logic [ISSUE_WIDTH-1:0]     out_pred_taken_o,
  input  logic [ISSUE_WIDTH-1:0]     out_accept_i,
  output logic [DEPTH_W:0]           count_o
);

  localparam int CNT_W = DEPTH_W + 1;
  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_FAULT_HOLD = 1'b1;

  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:0]         state_q, state_d;

  // Queue storage; contents are deliberately left unreset.
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic        mem_pt    [DEPTH];
  logic        mem_ff    [DEPTH];
  logic        mem_fp    [DEPTH];

  // Packet after compaction: entry j is the j-th entry this packet contributes.
  logic [31:0]            cmp_instr [FETCH_WIDTH];
  logic [31:0]            cmp_pc    [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] cmp_pt, cmp_ff, cmp_fp;
  logic [CNT_W-1:0]       push_cnt;
  logic                   is_fault;
  logic                   push;
  logic                   byp_active;

  logic [CNT_W-1:0]       pop_cnt;
  logic                   pop_run;
  logic [CNT_W-1:0]       skip_cnt;
  logic [CNT_W-1:0]       rd_adv;
  logic [CNT_W-1:0]       pushed_cnt;
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [DEPTH_W-1:0]     wr_addr [FETCH_WIDTH];

  // Fetch is taken only as whole packets, judged on the registered count alone.
  assign in_accept_o = !rst_i && (state_q == ST_RUN) &&
                       (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign push    = in_valid_i && in_accept_o && !flush_i;
  assign count_o = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_active = push && (count_q == '0) && (state_q == ST_RUN);
`else
  assign byp_active = 1'b0;
`endif

  // Compact masked slots into ascending entries; a fault packet becomes one marker entry.
  always_comb begin
    is_fault = in_fault_fetch_i | in_fault_page_i;
    push_cnt = '0;
    cmp_pt   = '0;
    cmp_ff   = '0;
    cmp_fp   = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      cmp_instr[j] = '0;
      cmp_pc[j]    = '0;
    end
    if (is_fault) begin
      push_cnt  = CNT_W'(1);
      cmp_ff[0] = in_fault_fetch_i;
      cmp_fp[0] = in_fault_page_i;
      cmp_pc[0] = in_pc_i;
      cmp_pt[0] = in_pred_taken_i[0];
      // Descending scan so the lowest masked slot is the one that sticks.
      for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
        if (in_mask_i[k]) begin
          cmp_pc[0] = in_pc_i + 32'(4 * k);
          cmp_pt[0] = in_pred_taken_i[k];
        end
      end
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (in_mask_i[k]) begin
          for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (push_cnt == CNT_W'(j)) begin
              cmp_instr[j] = in_instr_i[32*k +: 32];
              cmp_pc[j]    = in_pc_i + 32'(4 * k);
              cmp_pt[j]    = in_pred_taken_i[k];
            end
          end
          push_cnt = push_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Output lanes read storage from rd_ptr, or the compacted packet when bypassing.
  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
    logic [DEPTH_W-1:0] lane_idx;
    logic               stored_vld;
    assign lane_idx   = rd_ptr_q + DEPTH_W'(gi);
    assign stored_vld = (count_q > CNT_W'(gi)) && !flush_i && !rst_i;
    if (gi < FETCH_WIDTH) begin : g_byp
      assign out_valid_o[gi]          = byp_active ? (push_cnt > CNT_W'(gi)) : stored_vld;
      assign out_instr_o[32*gi +: 32] = byp_active ? cmp_instr[gi] : mem_instr[lane_idx];
      assign out_pc_o[32*gi +: 32]    = byp_active ? cmp_pc[gi]    : mem_pc[lane_idx];
      assign out_pred_taken_o[gi]     = byp_active ? cmp_pt[gi]    : mem_pt[lane_idx];
      assign out_fault_fetch_o[gi]    = byp_active ? cmp_ff[gi]    : mem_ff[lane_idx];
      assign out_fault_page_o[gi]     = byp_active ? cmp_fp[gi]    : mem_fp[lane_idx];
    end else begin : g_mem
      assign out_valid_o[gi]          = stored_vld && !byp_active;
      assign out_instr_o[32*gi +: 32] = mem_instr[lane_idx];
      assign out_pc_o[32*gi +: 32]    = mem_pc[lane_idx];
      assign out_pred_taken_o[gi]     = mem_pt[lane_idx];
      assign out_fault_fetch_o[gi]    = mem_ff[lane_idx];
      assign out_fault_page_o[gi]     = mem_fp[lane_idx];
    end
  end

  // Pop count is the unbroken run of accepted valid lanes starting at lane 0.
  always_comb begin
    pop_cnt = '0;
    pop_run = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      pop_run = pop_run & out_accept_i[k] & out_valid_o[k];
      if (pop_run) pop_cnt = pop_cnt + CNT_W'(1);
    end
  end

  // Write enables and addresses; bypassed entries popped this cycle are skipped.
  always_comb begin
    skip_cnt   = byp_active ? pop_cnt : '0;
    rd_adv     = byp_active ? '0 : pop_cnt;
    pushed_cnt = push ? push_cnt : '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      wr_en[j]   = push && (CNT_W'(j) < push_cnt) && (CNT_W'(j) >= skip_cnt);
      wr_addr[j] = wr_ptr_q + DEPTH_W'(j) - skip_cnt[DEPTH_W-1:0];
    end
  end

  // Next-state for pointers, occupancy and the fault-hold state.
  always_comb begin
    rd_ptr_d = rd_ptr_q + rd_adv[DEPTH_W-1:0];
    wr_ptr_d = wr_ptr_q + DEPTH_W'(pushed_cnt - skip_cnt);
    count_d  = count_q + pushed_cnt - pop_cnt;
    state_d  = state_q;
    if (push && is_fault) state_d = ST_FAULT_HOLD;
  end

  // Storage write port, one lane per compacted entry.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (wr_en[j]) begin
        mem_instr[wr_addr[j]] <= cmp_instr[j];
        mem_pc[wr_addr[j]]    <= cmp_pc[j];
        mem_pt[wr_addr[j]]    <= cmp_pt[j];
        mem_ff[wr_addr[j]]    <= cmp_ff[j];
        mem_fp[wr_addr[j]]    <= cmp_fp[j];
      end
    end
  end

  // Control registers; a flush empties the queue exactly as reset does.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_RUN;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

endmodule
